// File: rtl/fdtd_pkg.sv
// Shared types for the FDTD field-buffer loader: FSM states, field selects
// and the field-to-buffer-strobe mapping.
package fdtd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_START  = 2'd1,
      ST_FETCH  = 2'd2,
      ST_FINISH = 2'd3
   } fdtd_ld_state_e;

   typedef enum logic [1:0] {
      FLD_HY  = 2'd0,
      FLD_EZ  = 2'd1,
      FLD_SRC = 2'd2
   } fdtd_field_e;

   localparam int unsigned MAX_OUTSTANDING = 2;

   // Strobe vector ordering is {src, Ez, Hy}.
   function automatic logic [2:0] fld_onehot(input fdtd_field_e f);
      logic [2:0] oh;
      case (f)
         FLD_HY:  oh = 3'b001;
         FLD_EZ:  oh = 3'b010;
         FLD_SRC: oh = 3'b100;
         default: oh = 3'b000;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/fdtd_mem_loader.sv
// Streams a block of field words from data memory into one accelerator buffer,
// keeping at most two reads in flight and framing the transfer with start/end pulses.
module fdtd_mem_loader
   import fdtd_pkg::*;
#(
   parameter int FDTD_DATA_WIDTH   = 32,
   parameter int BUFFER_ADDR_WIDTH = 6,
   parameter int MEM_ADDR_WIDTH    = 32
) (
   input  logic                       CLK,
   input  logic                       RST_N,
   input  logic                       start_i,
   input  logic [1:0]                 field_sel_i,
   input  logic [MEM_ADDR_WIDTH-1:0]  base_addr_i,
   input  logic [FDTD_DATA_WIDTH-1:0] buffer_size_i,
   output logic                       busy_o,
   output logic                       done_o,
   output logic                       err_o,
   output logic                       mem_req_o,
   output logic [MEM_ADDR_WIDTH-1:0]  mem_addr_o,
   input  logic                       mem_gnt_i,
   input  logic                       mem_rvalid_i,
   input  logic [FDTD_DATA_WIDTH-1:0] mem_rdata_i,
   output logic                       buffer_Hy_start_o,
   output logic                       buffer_Ez_start_o,
   output logic                       buffer_src_start_o,
   output logic                       buffer_Hy_end_o,
   output logic                       buffer_Ez_end_o,
   output logic                       buffer_src_end_o,
   output logic                       wrtvalid_Hy_old_o,
   output logic [FDTD_DATA_WIDTH-1:0] Hy_old_o,
   output logic                       wrtvalid_Ez_old_o,
   output logic [FDTD_DATA_WIDTH-1:0] Ez_old_o
);

   localparam int CW = BUFFER_ADDR_WIDTH + 1;
   localparam logic [FDTD_DATA_WIDTH-1:0] MAX_SIZE = FDTD_DATA_WIDTH'(2 ** BUFFER_ADDR_WIDTH);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   fdtd_ld_state_e            state;
   fdtd_field_e               field;
   logic [MEM_ADDR_WIDTH-1:0] base;
   logic [CW-1:0]             size;
   logic [CW-1:0]             req_cnt;
   logic [CW-1:0]             rsp_cnt;
   logic [1:0]                outstanding;
   logic [2:0]                start_p;
   logic [2:0]                end_p;
   logic                      params_ok;
   logic                      req_acc;
   logic                      rsp_acc;

   assign params_ok  = (field_sel_i != 2'd3) && (buffer_size_i <= MAX_SIZE);
   assign mem_req_o  = (state == ST_FETCH) && (req_cnt < size) &&
                       (outstanding < 2'(MAX_OUTSTANDING));
   // Word index to byte offset; the add wraps at the memory address width.
   assign mem_addr_o = base + (MEM_ADDR_WIDTH'(req_cnt) << 2);
   assign req_acc    = mem_req_o && mem_gnt_i;
   assign rsp_acc    = (state == ST_FETCH) && mem_rvalid_i;
   assign busy_o     = (state != ST_IDLE);

   assign buffer_Hy_start_o  = start_p[0];
   assign buffer_Ez_start_o  = start_p[1];
   assign buffer_src_start_o = start_p[2];
   assign buffer_Hy_end_o    = end_p[0];
   assign buffer_Ez_end_o    = end_p[1];
   assign buffer_src_end_o   = end_p[2];

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state             <= ST_IDLE;
         field             <= FLD_HY;
         base              <= '0;
         size              <= '0;
         req_cnt           <= '0;
         rsp_cnt           <= '0;
         outstanding       <= '0;
         start_p           <= '0;
         end_p             <= '0;
         done_o            <= 1'b0;
         err_o             <= 1'b0;
         wrtvalid_Hy_old_o <= 1'b0;
         wrtvalid_Ez_old_o <= 1'b0;
         Hy_old_o          <= '0;
         Ez_old_o          <= '0;
      end else begin
         start_p           <= '0;
         end_p             <= '0;
         done_o            <= 1'b0;
         err_o             <= 1'b0;
         wrtvalid_Hy_old_o <= 1'b0;
         wrtvalid_Ez_old_o <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (start_i) begin
                  if (params_ok) begin
                     field       <= fdtd_field_e'(field_sel_i);
                     base        <= base_addr_i;
                     size        <= buffer_size_i[CW-1:0];
                     req_cnt     <= '0;
                     rsp_cnt     <= '0;
                     outstanding <= '0;
                     start_p     <= fld_onehot(fdtd_field_e'(field_sel_i));
                     state       <= ST_START;
                  end else begin
                     err_o <= 1'b1;
                  end
               end
            end

            ST_START: begin
               if (size == '0) begin
                  end_p  <= fld_onehot(field);
                  done_o <= 1'b1;
                  state  <= ST_FINISH;
               end else begin
                  state <= ST_FETCH;
               end
            end

            ST_FETCH: begin
               if (req_acc) begin
                  req_cnt <= req_cnt + CNT_ONE;
               end
               // Simultaneous grant and response cancel out.
               case ({req_acc, rsp_acc})
                  2'b10:   outstanding <= outstanding + 2'd1;
                  2'b01:   outstanding <= outstanding - 2'd1;
                  default: outstanding <= outstanding;
               endcase
               if (rsp_acc) begin
                  rsp_cnt <= rsp_cnt + CNT_ONE;
                  if (field == FLD_HY) begin
                     wrtvalid_Hy_old_o <= 1'b1;
                     Hy_old_o          <= mem_rdata_i;
                  end else begin
                     wrtvalid_Ez_old_o <= 1'b1;
                     Ez_old_o          <= mem_rdata_i;
                  end
                  if (rsp_cnt + CNT_ONE == size) begin
                     end_p  <= fld_onehot(field);
                     done_o <= 1'b1;
                     state  <= ST_FINISH;
                  end
               end
            end

            ST_FINISH: begin
               state <= ST_IDLE;
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fdtd_mem_loader.sv
// Scoreboard bench for fdtd_mem_loader: a memory model with configurable grant
// stalls and read latency feeds expected writes into a queue checked at the DUT outputs.
module tb_fdtd_mem_loader;
   import fdtd_pkg::*;

   localparam int DW  = 32;
   localparam int BAW = 6;
   localparam int AW  = 32;

   logic          CLK = 1'b0;
   logic          RST_N = 1'b0;
   logic          start_i = 1'b0;
   logic [1:0]    field_sel_i = 2'd0;
   logic [AW-1:0] base_addr_i = '0;
   logic [DW-1:0] buffer_size_i = '0;
   logic          busy_o, done_o, err_o;
   logic          mem_req_o;
   logic [AW-1:0] mem_addr_o;
   logic          mem_gnt_i = 1'b0;
   logic          mem_rvalid_i = 1'b0;
   logic [DW-1:0] mem_rdata_i = '0;
   logic          buffer_Hy_start_o, buffer_Ez_start_o, buffer_src_start_o;
   logic          buffer_Hy_end_o, buffer_Ez_end_o, buffer_src_end_o;
   logic          wrtvalid_Hy_old_o, wrtvalid_Ez_old_o;
   logic [DW-1:0] Hy_old_o, Ez_old_o;

   fdtd_mem_loader #(
      .FDTD_DATA_WIDTH(DW),
      .BUFFER_ADDR_WIDTH(BAW),
      .MEM_ADDR_WIDTH(AW)
   ) dut (
      .CLK(CLK), .RST_N(RST_N), .start_i(start_i), .field_sel_i(field_sel_i),
      .base_addr_i(base_addr_i), .buffer_size_i(buffer_size_i),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
      .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
      .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
      .buffer_Hy_start_o(buffer_Hy_start_o), .buffer_Ez_start_o(buffer_Ez_start_o),
      .buffer_src_start_o(buffer_src_start_o), .buffer_Hy_end_o(buffer_Hy_end_o),
      .buffer_Ez_end_o(buffer_Ez_end_o), .buffer_src_end_o(buffer_src_end_o),
      .wrtvalid_Hy_old_o(wrtvalid_Hy_old_o), .Hy_old_o(Hy_old_o),
      .wrtvalid_Ez_old_o(wrtvalid_Ez_old_o), .Ez_old_o(Ez_old_o)
   );

   always #5 CLK = ~CLK;

   int errs = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   typedef struct { logic hy; logic [DW-1:0] d; } exp_t;
   typedef struct { logic [DW-1:0] d; int rdy; } rsp_t;
   exp_t exp_q[$];
   rsp_t pend_q[$];

   logic [1:0]    cur_fld = 2'd0;
   logic [AW-1:0] cur_base = '0;
   int            cur_size = 0;
   int            seed = 0;
   int            gmode = 0;
   int            lat = 1;
   bit            exp_on = 1'b0;
   int            cyc = 0;
   int            gcount = 0, wcount = 0, wtotal = 0;
   int            done_cnt = 0, start_cnt = 0, req_cycles = 0;
   int            start_cyc = 0, done_cyc = 0, waitc = 0;
   bit            holding = 1'b0;
   logic [AW-1:0] held_addr = '0;
   logic [DW-1:0] md;
   exp_t          e;

   function automatic logic [2:0] onehot(input logic [1:0] f);
      return (f == 2'd0) ? 3'b001 : (f == 2'd1) ? 3'b010 : 3'b100;
   endfunction

   // Memory model: in-order responses `lat` cycles after grant, optional 2-cycle grant stall.
   initial forever begin
      @(negedge CLK);
      cyc++;
      mem_rvalid_i = 1'b0;
      if (pend_q.size() > 0 && pend_q[0].rdy <= cyc) begin
         mem_rvalid_i = 1'b1;
         mem_rdata_i  = pend_q[0].d;
         if (exp_on) exp_q.push_back('{hy: (cur_fld == 2'd0), d: pend_q[0].d});
         void'(pend_q.pop_front());
      end
      mem_gnt_i = 1'b0;
      if (RST_N && mem_req_o) begin
         req_cycles++;
         if (holding) chk("addr_hold", 64'(mem_addr_o), 64'(held_addr));
         if (gmode == 0 || waitc >= 2) begin
            mem_gnt_i = 1'b1;
            waitc     = 0;
            holding   = 1'b0;
            chk("addr", 64'(mem_addr_o), 64'(AW'(cur_base + AW'(4 * gcount))));
            chk("os_lt2", 64'((pend_q.size() + int'(mem_rvalid_i)) < 2), 64'(1));
            md = DW'(seed + gcount + 1);
            pend_q.push_back('{d: md, rdy: cyc + lat});
            gcount++;
         end else begin
            waitc++;
            holding   = 1'b1;
            held_addr = mem_addr_o;
         end
      end else begin
         holding = 1'b0;
      end
   end

   // Output monitor: pops the scoreboard on every write and checks framing pulses.
   initial forever begin
      @(negedge CLK);
      if (wrtvalid_Hy_old_o || wrtvalid_Ez_old_o) begin
         wtotal++;
         wcount++;
         if (exp_q.size() == 0) begin
            chk("unexp_wr", 64'(1), 64'(0));
         end else begin
            e = exp_q.pop_front();
            chk("wr_field", 64'({wrtvalid_Hy_old_o, wrtvalid_Ez_old_o}), 64'({e.hy, ~e.hy}));
            chk("wr_data", 64'(e.hy ? Hy_old_o : Ez_old_o), 64'(e.d));
         end
      end
      if ({buffer_src_start_o, buffer_Ez_start_o, buffer_Hy_start_o} != 3'b000) begin
         start_cnt++;
         start_cyc = cyc;
         chk("start_sel", 64'({buffer_src_start_o, buffer_Ez_start_o, buffer_Hy_start_o}),
             64'(onehot(cur_fld)));
      end
      if (done_o || {buffer_src_end_o, buffer_Ez_end_o, buffer_Hy_end_o} != 3'b000) begin
         done_cnt++;
         done_cyc = cyc;
         chk("end_sel", 64'({buffer_src_end_o, buffer_Ez_end_o, buffer_Hy_end_o, done_o}),
             64'({onehot(cur_fld), 1'b1}));
         chk("done_last", 64'(wcount), 64'(cur_size));
      end
   end

   task automatic issue(input logic [1:0] f, input logic [AW-1:0] b, input logic [DW-1:0] s);
      @(posedge CLK); #2;
      field_sel_i   = f;
      base_addr_i   = b;
      buffer_size_i = s;
      start_i       = 1'b1;
      @(posedge CLK); #2;
      start_i = 1'b0;
   endtask

   task automatic begin_load(input logic [1:0] f, input logic [AW-1:0] b, input int s,
                             input int gm, input int lt, input int sd);
      cur_fld = f; cur_base = b; cur_size = s;
      gmode = gm; lat = lt; seed = sd;
      gcount = 0; wcount = 0; done_cnt = 0; start_cnt = 0; req_cycles = 0; waitc = 0;
      exp_on = 1'b1;
      issue(f, b, DW'(s));
      @(negedge CLK);
      chk("busy_run", 64'(busy_o), 64'(1));
   endtask

   task automatic finish_load(input string tag);
      for (int i = 0; i < 2000 && done_cnt == 0; i++) @(negedge CLK);
      if (done_cnt == 0) chk({tag, "_timeout"}, 64'(0), 64'(1));
      repeat (3) @(negedge CLK);
      chk({tag, "_wr_count"}, 64'(wcount), 64'(cur_size));
      chk({tag, "_starts"}, 64'(start_cnt), 64'(1));
      chk({tag, "_dones"}, 64'(done_cnt), 64'(1));
      chk({tag, "_exp_empty"}, 64'(exp_q.size()), 64'(0));
      chk({tag, "_idle"}, 64'(busy_o), 64'(0));
   endtask

   task automatic bad_load(input string tag, input logic [1:0] f, input logic [DW-1:0] s);
      start_cnt = 0;
      issue(f, 32'h500, s);
      @(negedge CLK);
      chk({tag, "_err"}, 64'(err_o), 64'(1));
      chk({tag, "_busy"}, 64'(busy_o), 64'(0));
      @(negedge CLK);
      chk({tag, "_err_pulse"}, 64'(err_o), 64'(0));
      chk({tag, "_no_start"}, 64'(start_cnt), 64'(0));
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_ctrl"}, 64'({busy_o, done_o, err_o, mem_req_o,
                               buffer_Hy_start_o, buffer_Ez_start_o, buffer_src_start_o,
                               buffer_Hy_end_o, buffer_Ez_end_o, buffer_src_end_o,
                               wrtvalid_Hy_old_o, wrtvalid_Ez_old_o}), 64'(0));
      chk({tag, "_addr"}, 64'(mem_addr_o), 64'(0));
      chk({tag, "_hy"}, 64'(Hy_old_o), 64'(0));
      chk({tag, "_ez"}, 64'(Ez_old_o), 64'(0));
   endtask

   int w0;

   initial begin
      repeat (3) @(posedge CLK);
      #2 RST_N = 1'b1;
      @(negedge CLK);
      chk_zero("reset");

      // Hy, 4 words, immediate grant, 1-cycle read latency: data 1..4.
      begin_load(2'd0, 32'h100, 4, 0, 1, 0);
      finish_load("hy4");

      // Ez, 3 words, grant stalled 2 cycles per request.
      begin_load(2'd1, 32'h200, 3, 1, 1, 50);
      finish_load("ez3");

      // src routes to the Ez write port.
      begin_load(2'd2, 32'h300, 4, 0, 1, 70);
      finish_load("src4");

      // Empty src load: start then end/done next cycle, no memory traffic.
      begin_load(2'd2, 32'h0, 0, 0, 1, 0);
      finish_load("src0");
      chk("src0_noreq", 64'(req_cycles), 64'(0));
      chk("src0_gap", 64'(done_cyc - start_cyc), 64'(1));

      // Illegal requests.
      bad_load("size65", 2'd0, 32'd65);
      bad_load("fld3", 2'd3, 32'd4);

      // Full buffer with address wrap and slow responses.
      begin_load(2'd1, 32'hFFFF_FFF0, 64, 0, 2, 500);
      finish_load("ez64");

      // Long latency forces the two-outstanding limit; a second start is ignored.
      begin_load(2'd0, 32'h400, 8, 0, 3, 200);
      repeat (4) @(posedge CLK);
      issue(2'd1, 32'h900, 32'd3);
      finish_load("hy8");

      // Reset after two grants of a five-word load.
      begin_load(2'd0, 32'h2000, 5, 0, 4, 100);
      for (int i = 0; i < 50 && gcount < 2; i++) @(negedge CLK);
      chk("rst_two_grants", 64'(gcount), 64'(2));
      @(posedge CLK); #2;
      RST_N  = 1'b0;
      exp_on = 1'b0;
      exp_q.delete();
      @(posedge CLK); #2;
      RST_N = 1'b1;
      @(negedge CLK);
      chk_zero("midrst");
      w0 = wtotal;
      for (int i = 0; i < 20 && pend_q.size() > 0; i++) @(negedge CLK);
      repeat (3) @(negedge CLK);
      chk("rst_late_rvalid_seen", 64'(pend_q.size()), 64'(0));
      chk("rst_no_wr", 64'(wtotal - w0), 64'(0));
      chk("rst_no_done", 64'(done_cnt), 64'(0));

      begin_load(2'd0, 32'h3000, 2, 0, 1, 300);
      finish_load("post_rst");

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
